// File: rtl/tick_prescaler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tick_prescaler                                               |
// | Description : Divides the system clock into one-cycle game-time ticks      |
// |               that drive the countdown's count-clock input. Also provides  |
// |               a 50%-duty blink level for digit flashing and a saturating   |
// |               count of ticks since the last resync.                        |
// |                                                                            |
// | Ports       : clk        - system clock, rising edge                       |
// |               reset      - asynchronous, active-high reset                 |
// |               start_sync - one-cycle pulse, restarts the tick phase        |
// |               pause      - level, freezes the divider and blocks ticks     |
// |               fast       - level, selects the DIV_FAST period              |
// |               slowmo     - level, halves the tick rate (optional)          |
// |               tick       - one-clk pulse per period                        |
// |               blink      - 0 first half of the period, 1 second half       |
// |               tick_count - ticks since resync/reset, saturates at 255      |
// |                                                                            |
// | Option      : define TICK_SLOWMO_EN to add the slowmo port and phase bit.  |
// |                                                                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tick_prescaler #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int TICK_HZ     = 1,
  parameter int FAST_MULT   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_sync,
  input  logic       pause,
  input  logic       fast,
`ifdef TICK_SLOWMO_EN
  input  logic       slowmo,
`endif
  output logic       tick,
  output logic       blink,
  output logic [7:0] tick_count
);

  localparam int DIV      = CLK_FREQ_HZ / TICK_HZ;
  localparam int DIV_FAST = DIV / FAST_MULT;
  localparam int CW       = $clog2(DIV);

  // Terminal and half-period compare values, held as cnt-width constants so
  // that a power-of-two DIV (which does not itself fit in CW bits) still works.
  localparam logic [CW-1:0] C_DIV_M1       = CW'(DIV - 1);
  localparam logic [CW-1:0] C_DIV_HALF_M1  = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] C_FAST_M1      = CW'(DIV_FAST - 1);
  localparam logic [CW-1:0] C_FAST_HALF_M1 = CW'(DIV_FAST / 2 - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;
  logic          blink_q, blink_d;
  logic [7:0]    tick_count_q, tick_count_d;

  logic [CW-1:0] limit_m1;
  logic [CW-1:0] half_m1;
  logic          wrap;
  logic          do_tick;

`ifdef TICK_SLOWMO_EN
  logic          phase_q, phase_d;
`endif

  // Limit is re-evaluated every cycle, so raising fast with cnt already past
  // the short terminal value wraps immediately (">=" rather than "==").
  always_comb begin
    limit_m1 = fast ? C_FAST_M1      : C_DIV_M1;
    half_m1  = fast ? C_FAST_HALF_M1 : C_DIV_HALF_M1;
    wrap     = (cnt_q >= limit_m1);
  end

  always_comb begin
    cnt_d        = cnt_q;
    tick_d       = 1'b0;
    blink_d      = blink_q;
    tick_count_d = tick_count_q;
    do_tick      = 1'b0;
`ifdef TICK_SLOWMO_EN
    phase_d      = slowmo ? phase_q : 1'b0;
`endif

    if (start_sync) begin
      // Resync beats pause and any coincident wrap: no tick this cycle.
      cnt_d        = '0;
      blink_d      = 1'b0;
      tick_count_d = '0;
`ifdef TICK_SLOWMO_EN
      phase_d      = 1'b0;
`endif
    end else if (pause) begin
      // Hold phase; tick_d already defaults low.
      cnt_d = cnt_q;
    end else if (wrap) begin
      cnt_d   = '0;
      blink_d = 1'b0;
`ifdef TICK_SLOWMO_EN
      // In slow-motion only every second wrap produces a tick.
      if (slowmo) begin
        phase_d = ~phase_q;
        do_tick = phase_q;
      end else begin
        do_tick = 1'b1;
      end
`else
      do_tick = 1'b1;
`endif
      if (do_tick) begin
        tick_d = 1'b1;
        if (tick_count_q != 8'hFF) begin
          tick_count_d = tick_count_q + 8'd1;
        end
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == half_m1) begin
        blink_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      tick_q       <= 1'b0;
      blink_q      <= 1'b0;
      tick_count_q <= '0;
    end else begin
      cnt_q        <= cnt_d;
      tick_q       <= tick_d;
      blink_q      <= blink_d;
      tick_count_q <= tick_count_d;
    end
  end

`ifdef TICK_SLOWMO_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
    end
  end
`endif

  assign tick       = tick_q;
  assign blink      = blink_q;
  assign tick_count = tick_count_q;

endmodule
`default_nettype wire

// File: tb/tb_tick_prescaler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_tick_prescaler                                            |
// | Description : Self-checking bench for tick_prescaler with DIV=20 and       |
// |               DIV_FAST=5. Outputs are sampled 1 time unit after each       |
// |               rising edge; "edge k" below means the k-th rising edge       |
// |               after reset release.                                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_tick_prescaler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_sync = 1'b0;
  logic       pause = 1'b0;
  logic       fast = 1'b0;
`ifdef TICK_SLOWMO_EN
  logic       slowmo = 1'b0;
`endif
  logic       tick;
  logic       blink;
  logic [7:0] tick_count;

  int n_total = 0;
  int n_pass  = 0;

  tick_prescaler #(
    .CLK_FREQ_HZ(20),
    .TICK_HZ    (1),
    .FAST_MULT  (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start_sync(start_sync),
    .pause     (pause),
    .fast      (fast),
`ifdef TICK_SLOWMO_EN
    .slowmo    (slowmo),
`endif
    .tick      (tick),
    .blink     (blink),
    .tick_count(tick_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int         n;
    logic       ss;
    logic       pz;
    logic       fs;
    logic       e_tick;
    logic       e_blink;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t vecs[25];

  int ticks;
  int consec;
  logic prev_tick;

  initial begin
    // Each record: drive inputs, clock n edges, then compare outputs.
    vecs[0]  = '{9,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}; // edge 9
    vecs[1]  = '{1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0}; // edge 10 blink rises
    vecs[2]  = '{9,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0}; // edge 19
    vecs[3]  = '{1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1}; // edge 20 first tick
    vecs[4]  = '{1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1}; // edge 21 tick gone
    vecs[5]  = '{19, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2}; // edge 40
    vecs[6]  = '{20, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3}; // edge 60
    vecs[7]  = '{5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3}; // cnt=5
    vecs[8]  = '{10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3}; // paused, cnt held 5
    vecs[9]  = '{4,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3}; // cnt=9
    vecs[10] = '{1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3}; // blink rises
    vecs[11] = '{9,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3}; // cnt=19
    vecs[12] = '{1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd4}; // delayed tick
    vecs[13] = '{8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4}; // cnt=8
    vecs[14] = '{1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0}; // sync beats pause
    vecs[15] = '{19, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0}; // cnt=19
    vecs[16] = '{1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1}; // full period after sync
    vecs[17] = '{19, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1}; // cnt=19 again
    vecs[18] = '{1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}; // sync on wrap: no tick
    vecs[19] = '{9,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}; // cnt=9
    vecs[20] = '{1,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1}; // fast: immediate wrap
    vecs[21] = '{2,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1}; // fast half-period blink
    vecs[22] = '{3,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2}; // fast period = 5
    vecs[23] = '{10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2}; // back to slow, cnt=10
    vecs[24] = '{10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3}; // continues to DIV

    // Reset state, held across edges.
    repeat (3) step();
    check("reset_tick", 32'(tick), 32'd0);
    check("reset_blink", 32'(blink), 32'd0);
    check("reset_count", 32'(tick_count), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 25; i++) begin
      start_sync = vecs[i].ss;
      pause      = vecs[i].pz;
      fast       = vecs[i].fs;
      for (int k = 0; k < vecs[i].n; k++) step();
      check($sformatf("vec%0d_tick", i), 32'(tick), 32'(vecs[i].e_tick));
      check($sformatf("vec%0d_blink", i), 32'(blink), 32'(vecs[i].e_blink));
      check($sformatf("vec%0d_count", i), 32'(tick_count), 32'(vecs[i].e_cnt));
    end

    // Saturation: 300 fast periods from a fresh sync.
    start_sync = 1'b1;
    fast       = 1'b1;
    step();
    start_sync = 1'b0;
    ticks      = 0;
    consec     = 0;
    prev_tick  = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      step();
      if (tick) ticks++;
      if (tick && prev_tick) consec++;
      prev_tick = tick;
    end
    check("sat_tick_total", 32'(ticks), 32'd300);
    check("sat_no_back_to_back", 32'(consec), 32'd0);
    check("sat_count", 32'(tick_count), 32'd255);
    ticks = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (tick) ticks++;
    end
    check("sat_tick_still_pulses", 32'(ticks), 32'd10);
    check("sat_count_held", 32'(tick_count), 32'd255);

    // Reset mid-period: cnt=2, blink high, count 255 -> cleared without a clock edge.
    repeat (2) step();
    check("pre_reset_blink", 32'(blink), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_blink", 32'(blink), 32'd0);
    check("async_reset_count", 32'(tick_count), 32'd0);
    check("async_reset_tick", 32'(tick), 32'd0);
    step();
    check("reset_held_count", 32'(tick_count), 32'd0);
    fast  = 1'b0;
    reset = 1'b0;

    // First period after a mid-period reset is a full DIV.
    repeat (19) step();
    check("post_reset_no_tick", 32'(tick), 32'd0);
    step();
    check("post_reset_tick", 32'(tick), 32'd1);

`ifdef TICK_SLOWMO_EN
    reset  = 1'b1;
    step();
    reset  = 1'b0;
    slowmo = 1'b1;
    repeat (20) step();
    check("slowmo_skip_tick", 32'(tick), 32'd0);
    check("slowmo_skip_count", 32'(tick_count), 32'd0);
    repeat (10) step();
    check("slowmo_blink", 32'(blink), 32'd1);
    repeat (10) step();
    check("slowmo_tick40", 32'(tick), 32'd1);
    check("slowmo_count40", 32'(tick_count), 32'd1);
    repeat (40) step();
    check("slowmo_tick80", 32'(tick), 32'd1);
    repeat (5) step();
    check("slowmo_count85", 32'(tick_count), 32'd2);
    slowmo = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
